// File: rtl/nonce_scheduler.sv
// Nonce range scheduler: feeds a hashing core one nonce per cadence slot, waits
// for the pipeline to drain, and buffers golden-nonce hits in a 2-entry FIFO.
module nonce_scheduler #(
    parameter int LOOP_LOG2    = 0,
    parameter int DRAIN_CYCLES = 135
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         work_load,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data,
    input  logic [31:0]  work_nonce_start,
    input  logic [31:0]  work_nonce_end,
    output logic [255:0] core_midstate,
    output logic [95:0]  core_data,
    output logic [31:0]  core_nonce,
    output logic         core_issue,
    input  logic         core_hit,
    input  logic [31:0]  core_hit_nonce,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [31:0]  result_nonce,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    localparam int              CW         = (LOOP_LOG2 > 0) ? LOOP_LOG2 : 1;
    localparam logic [CW-1:0]   CAD_STEP   = (LOOP_LOG2 > 0) ? CW'(1) : CW'(0);
    localparam logic [9:0]      DRAIN_LAST = 10'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [255:0]   r_midstate;
    logic [95:0]    r_data;
    logic [31:0]    r_nonce;
    logic [31:0]    r_end;
    logic [CW-1:0]  r_cadence;
    logic [9:0]     r_drain_cnt;
    logic [9:0]     r_blank_cnt;
    logic           r_issue;
    logic           r_done;
    logic           r_overflow;
    logic [31:0]    r_fifo0;
    logic [31:0]    r_fifo1;
    logic [1:0]     r_count;

    logic           w_busy;
    logic           w_last_issue;
    logic           w_drain_end;
    logic           w_issue_now;
    logic           w_blank;
    logic           w_push;
    logic           w_pop;

    assign w_busy       = (r_state != S_IDLE);
    assign w_last_issue = r_issue && (r_nonce == r_end);
    assign w_drain_end  = (r_state == S_DRAIN) && (r_drain_cnt == DRAIN_LAST);
    assign w_issue_now  = (r_state == S_RUN) && (r_cadence == {CW{1'b0}}) && !w_last_issue;
    // Hits are blanked from an abort load onward so stale pipeline results never reach the FIFO.
    assign w_blank      = (r_blank_cnt != 10'd0) || (work_load && w_busy);
    assign w_push       = core_hit && w_busy && !w_blank;
    assign w_pop        = (r_count != 2'd0) && result_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a work load restarts RUN from any state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_IDLE;
            S_RUN:   w_state_next = w_last_issue ? S_DRAIN : S_RUN;
            S_DRAIN: w_state_next = w_drain_end ? S_IDLE : S_DRAIN;
            default: w_state_next = S_IDLE;
        endcase
        if (work_load) begin
            w_state_next = S_RUN;
        end else begin
            w_state_next = w_state_next;
        end
    end

    // Work latch, issue cadence, nonce stepping and drain/blanking counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_midstate  <= 256'd0;
            r_data      <= 96'd0;
            r_nonce     <= 32'd0;
            r_end       <= 32'd0;
            r_cadence   <= {CW{1'b0}};
            r_drain_cnt <= 10'd0;
            r_blank_cnt <= 10'd0;
            r_issue     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_drain_end && !work_load;
            if (work_load) begin
                r_midstate  <= work_midstate;
                r_data      <= work_data;
                r_nonce     <= work_nonce_start;
                r_end       <= work_nonce_end;
                r_cadence   <= {CW{1'b0}};
                r_drain_cnt <= 10'd0;
                r_blank_cnt <= w_busy ? DRAIN_LAST : 10'd0;
                r_issue     <= 1'b0;
            end else begin
                r_issue <= w_issue_now;
                if (r_issue) begin
                    r_nonce <= r_nonce + 32'd1;
                end
                if (r_state == S_RUN) begin
                    r_cadence <= r_cadence + CAD_STEP;
                end
                if (r_state == S_DRAIN) begin
                    r_drain_cnt <= r_drain_cnt + 10'd1;
                end else begin
                    r_drain_cnt <= 10'd0;
                end
                if (r_blank_cnt != 10'd0) begin
                    r_blank_cnt <= r_blank_cnt - 10'd1;
                end
            end
        end
    end

    // Two-entry result FIFO (r_fifo0 is the head) and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fifo0    <= 32'd0;
            r_fifo1    <= 32'd0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    case (r_count)
                        2'd0: begin
                            r_fifo0 <= core_hit_nonce;
                            r_count <= 2'd1;
                        end
                        2'd1: begin
                            r_fifo1 <= core_hit_nonce;
                            r_count <= 2'd2;
                        end
                        default: r_count <= r_count;
                    endcase
                end
                2'b01: begin
                    r_fifo0 <= r_fifo1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_fifo0 <= core_hit_nonce;
                    end else begin
                        r_fifo0 <= r_fifo1;
                        r_fifo1 <= core_hit_nonce;
                    end
                end
                default: r_count <= r_count;
            endcase
            if (work_load) begin
                r_overflow <= 1'b0;
            end else if (w_push && !w_pop && (r_count == 2'd2)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign core_midstate = r_midstate;
    assign core_data     = r_data;
    assign core_nonce    = r_nonce;
    assign core_issue    = r_issue;
    assign result_valid  = (r_count != 2'd0);
    assign result_nonce  = r_fifo0;
    assign busy          = w_busy;
    assign done          = r_done;
    assign overflow      = r_overflow;

endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 SHALL have parameter LOOP_LOG2, default 0, core accepts one nonce every 2^LOOP_LOG2 cycles (legal 0..5).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 135, core pipeline depth in cycles after last issue (1..1023).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port work_load  input  1  strobe; latch new work this cycle.
REQ-006 SHALL have port work_midstate  input  256  SHA-256 midstate of new work.
REQ-007 SHALL have port work_data  input  96  block-header tail (excluding nonce).
REQ-008 SHALL have port work_nonce_start  input  32  first nonce of range.
REQ-009 SHALL have port work_nonce_end  input  32  last nonce of range, inclusive.
REQ-010 SHALL have port core_midstate  output  256  registered midstate to hashing core.
REQ-011 SHALL have port core_data  output  96  registered header tail to core.
REQ-012 SHALL have port core_nonce  output  32  nonce presented with core_issue.
REQ-013 SHALL have port core_issue  output  1  one-cycle strobe; core samples nonce.
REQ-014 SHALL have port core_hit  input  1  core reports golden nonce.
REQ-015 SHALL have port core_hit_nonce  input  32  nonce that produced the hit.
REQ-016 SHALL have port result_valid  output  1  result FIFO non-empty.
REQ-017 SHALL have port result_ready  input  1  consumer accepts result.
REQ-018 SHALL have port result_nonce  output  32  FIFO head nonce.
REQ-019 SHALL have port busy  output  1  state is RUN or DRAIN.
REQ-020 SHALL have port done  output  1  one-cycle pulse on DRAIN->IDLE.
REQ-021 SHALL have port overflow  output  1  sticky: a hit was dropped.

Function
REQ-022 SHALL implement states IDLE, RUN, DRAIN; the encoding is free.
REQ-023 SHALL on work_load in any state latch midstate/data to core outputs next cycle, load core_nonce=work_nonce_start, clear the cadence counter, clear overflow, and enter RUN.
REQ-024 SHALL in RUN assert core_issue for one cycle when the LOOP_LOG2-bit cadence counter is 0; first issue occurs the cycle after entering RUN.
REQ-025 SHALL increment core_nonce modulo 2^32 the cycle after each issue; end < start wraps through 0xFFFFFFFF to 0x00000000.
REQ-026 SHALL, when the issued nonce equals work_nonce_end (latched), enter DRAIN next cycle with no further issues; start==end issues exactly one nonce.
REQ-027 SHALL in DRAIN count DRAIN_CYCLES cycles, then enter IDLE and pulse done once.
REQ-028 SHALL accept core_hit in RUN and DRAIN, and drop it in IDLE without setting overflow.
REQ-029 SHALL on work_load during RUN/DRAIN (abort) blank core_hit for DRAIN_CYCLES cycles from the load; blanked hits are discarded, do not set overflow, and no done pulse is emitted for aborted work.
REQ-030 SHALL buffer accepted hits in a 2-entry FIFO; result_valid/result_nonce reflect the head, and a pop occurs on result_valid & result_ready.
REQ-031 SHALL, when full with simultaneous push and pop, perform both with no loss.
REQ-032 SHALL, when full with a push and no pop, drop the new hit and set overflow until reset or the next work_load.
REQ-033 SHALL preserve FIFO contents across work_load; the consumer drains old results.
REQ-034 SHALL have zero-cycle latency from core_hit to FIFO write (visible on result_valid the next cycle when empty).

Reset
REQ-035 SHALL when rst_n=0 at a clock edge enter IDLE; core_issue=0, core_nonce=0, core_midstate=0, core_data=0, result_valid=0, result_nonce=0, FIFO empty, busy=0, done=0, overflow=0, counters cleared.
REQ-036 SHALL give reset priority over work_load and core_hit in the same cycle, including mid-RUN and mid-DRAIN.

Verification
REQ-037 SHALL be verified by: LOOP_LOG2=0, load start=0x0E33327A, end=0x0E33337A -> 257 consecutive issues, 0x0E33327A..0x0E33337A, then DRAIN 135 cycles, then one done pulse.
REQ-038 SHALL be verified by: LOOP_LOG2=2, start=end=0x00000005 -> exactly one issue; issues spaced 4 cycles in a longer run.
REQ-039 SHALL be verified by: start=0xFFFFFFFE, end=0x00000001 -> issues FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-040 SHALL be verified by: hit 0x0E33337A with result_ready=0, then two more hits -> FIFO holds the first two, overflow=1; the next work_load clears overflow and keeps entries.
REQ-041 SHALL be verified by: work_load mid-RUN with a hit 3 cycles later -> hit discarded, new range issues from its start, no done for the aborted work.
REQ-042 SHALL be verified by: rst_n low mid-DRAIN with FIFO full -> all outputs at reset values next cycle.
